// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the forwarding select codes and the source-match helper.
package pipe_pkg;

    localparam int REG_W = 4;

    typedef logic [REG_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'b00,
        ST_RUN     = 2'b01,
        ST_LDSTALL = 2'b10,
        ST_FLUSH   = 2'b11
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // A source only matches if it is actually read; a hardwired r0 never matches anything.
    function automatic logic src_match(input logic use_rs, input reg_addr_t rs,
                                       input reg_addr_t rd, input logic r0_zero);
        return use_rs && (rs == rd) && !(r0_zero && (rd == '0));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-stage status inputs and control/forwarding outputs of the hazard controller.
// The master side is the datapath; the slave side is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_pkg::*;

    reg_addr_t        dec_rs1;
    reg_addr_t        dec_rs2;
    logic             dec_use_rs1;
    logic             dec_use_rs2;
    reg_addr_t        exe_rd;
    logic             exe_needs_wb;
    logic             exe_is_load;
    reg_addr_t        mem_wb_addr;
    logic             mem_wb_wen;
    reg_addr_t        wb_addr;
    logic             wb_wen;
    logic             br_taken;
    logic             perf_clr;

    logic             fetch_hold;
    logic             dec_hold;
    logic             exe_bubble;
    logic             dec_flush;
    logic             exe_flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               exe_rd, exe_needs_wb, exe_is_load,
               mem_wb_addr, mem_wb_wen, wb_addr, wb_wen,
               br_taken, perf_clr,
        input  fetch_hold, dec_hold, exe_bubble, dec_flush, exe_flush,
               fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               exe_rd, exe_needs_wb, exe_is_load,
               mem_wb_addr, mem_wb_wen, wb_addr, wb_wen,
               br_taken, perf_clr,
        output fetch_hold, dec_hold, exe_bubble, dec_flush, exe_flush,
               fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over an increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use stalls, operand bypass
// selects, post-reset decode hold, taken-branch flush and saturating perf counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int BOOT_CYCLES  = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter bit R0_ZERO      = 1'b1,
    parameter int CNT_W        = 16
) (
    input logic                  clk,
    input logic                  nrst,
    pipeline_hazard_ctrl_if.slave bus
);

    // The first flush cycle happens in RUN, so FLUSH only covers the remaining ones.
    localparam logic [15:0] BOOT_LOAD  = 16'(BOOT_CYCLES - 1);
    localparam logic [15:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 16'(FLUSH_CYCLES - 2) : 16'd0;

    state_t      state;
    state_t      next_state;
    logic [15:0] boot_left;
    logic [15:0] boot_left_nxt;
    logic [15:0] flush_left;
    logic [15:0] flush_left_nxt;

    logic        haz;
    logic        stall_inc;
    logic        flush_inc;
    logic        fetch_hold;
    logic        dec_hold;
    logic        exe_bubble;
    logic        dec_flush;
    logic        exe_flush;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;

    logic        a_exe, a_mem, a_wb;
    logic        b_exe, b_mem, b_wb;

    always_comb begin
        a_exe = src_match(bus.dec_use_rs1, bus.dec_rs1, bus.exe_rd, R0_ZERO);
        a_mem = src_match(bus.dec_use_rs1, bus.dec_rs1, bus.mem_wb_addr, R0_ZERO);
        a_wb  = src_match(bus.dec_use_rs1, bus.dec_rs1, bus.wb_addr, R0_ZERO);
        b_exe = src_match(bus.dec_use_rs2, bus.dec_rs2, bus.exe_rd, R0_ZERO);
        b_mem = src_match(bus.dec_use_rs2, bus.dec_rs2, bus.mem_wb_addr, R0_ZERO);
        b_wb  = src_match(bus.dec_use_rs2, bus.dec_rs2, bus.wb_addr, R0_ZERO);
        haz   = bus.exe_is_load && bus.exe_needs_wb && (a_exe || b_exe);
    end

    // Youngest producer wins; a load in EXE cannot forward and is covered by the stall instead.
    always_comb begin
        fwd_a_sel = FWD_REG;
        fwd_b_sel = FWD_REG;
        if (state != ST_BOOT) begin
            if (bus.exe_needs_wb && !bus.exe_is_load && a_exe) begin
                fwd_a_sel = FWD_EXE;
            end else if (bus.mem_wb_wen && a_mem) begin
                fwd_a_sel = FWD_MEM;
            end else if (bus.wb_wen && a_wb) begin
                fwd_a_sel = FWD_WB;
            end
            if (bus.exe_needs_wb && !bus.exe_is_load && b_exe) begin
                fwd_b_sel = FWD_EXE;
            end else if (bus.mem_wb_wen && b_mem) begin
                fwd_b_sel = FWD_MEM;
            end else if (bus.wb_wen && b_wb) begin
                fwd_b_sel = FWD_WB;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_BOOT;
            boot_left  <= BOOT_LOAD;
            flush_left <= FLUSH_LOAD;
        end else begin
            state      <= next_state;
            boot_left  <= boot_left_nxt;
            flush_left <= flush_left_nxt;
        end
    end

    // A taken branch outranks a load-use hazard: the stalled instruction is on the wrong path.
    always_comb begin
        next_state     = state;
        boot_left_nxt  = boot_left;
        flush_left_nxt = flush_left;
        fetch_hold     = 1'b0;
        dec_hold       = 1'b0;
        exe_bubble     = 1'b0;
        dec_flush      = 1'b0;
        exe_flush      = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        case (state)
            ST_BOOT: begin
                dec_hold = 1'b1;
                if (boot_left == '0) begin
                    next_state = ST_RUN;
                end else begin
                    boot_left_nxt = boot_left - 1'b1;
                end
            end
            ST_RUN, ST_LDSTALL: begin
                if (bus.br_taken) begin
                    dec_flush = 1'b1;
                    exe_flush = 1'b1;
                    flush_inc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        next_state     = ST_FLUSH;
                        flush_left_nxt = FLUSH_LOAD;
                    end else begin
                        next_state = ST_RUN;
                    end
                end else if (haz) begin
                    fetch_hold = 1'b1;
                    dec_hold   = 1'b1;
                    exe_bubble = 1'b1;
                    stall_inc  = 1'b1;
                    next_state = ST_LDSTALL;
                end else begin
                    next_state = ST_RUN;
                end
            end
            ST_FLUSH: begin
                dec_flush = 1'b1;
                exe_flush = 1'b1;
                if (flush_left == '0) begin
                    next_state = ST_RUN;
                end else begin
                    flush_left_nxt = flush_left - 1'b1;
                end
            end
            default: begin
                next_state = ST_BOOT;
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .nrst  (nrst),
        .inc   (stall_inc),
        .clr   (bus.perf_clr),
        .count (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .nrst  (nrst),
        .inc   (flush_inc),
        .clr   (bus.perf_clr),
        .count (bus.flush_cnt)
    );

    assign bus.fetch_hold = fetch_hold;
    assign bus.dec_hold   = dec_hold;
    assign bus.exe_bubble = exe_bubble;
    assign bus.dec_flush  = dec_flush;
    assign bus.exe_flush  = exe_flush;
    assign bus.fwd_a_sel  = fwd_a_sel;
    assign bus.fwd_b_sel  = fwd_b_sel;

endmodule
